ddr_dimm_responder: RTL and testbench

- DIMM-side responder for the testbench command interface. The controller raises act_cmd with an input_data_type payload, burst length (BL) and read preamble (RD_PRE).
- This block accepts the command and sequences ACT, preamble, burst and recovery phases. During these phases it drives dev_busy, dev_rw and dev_rd, then pulses next_cmd.
- A small flop-based memory stores write bursts and returns them on reads, so the memory checker can compare data.

---
 rtl/ddr_dimm_responder_pkg.sv | 36 +++
 rtl/ddr_dimm_responder_mem.sv | 29 ++
 rtl/ddr_dimm_responder.sv | 160 ++++++++++++++++
 tb/tb_ddr_dimm_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_dimm_responder_pkg.sv
// Shared types and constants for the DIMM-side command responder.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package ddr_dimm_responder_pkg;

    // Command payload presented alongside act_cmd. Only rw and the low
    // address bits are consumed by the responder.
    typedef struct packed {
        logic        rw;     // 0 = write, 1 = read
        logic [31:0] addr;   // word address, low AW bits used
    } input_data_type;

    typedef enum logic [2:0] {
        IDLE,
        ACT,
        PRE,
        BURST,
        RECOV
    } ddr_resp_state_t;

    localparam logic [1:0] DEV_RW_IDLE = 2'b00;
    localparam logic [1:0] DEV_RW_WR   = 2'b01;
    localparam logic [1:0] DEV_RW_RD   = 2'b10;

    // Low three address bits of beat 'idx' of a burst starting at 'start'.
    // BL8 wraps inside the aligned 8-word block; BL4 keeps bit 2 and wraps
    // inside the aligned 4-word block.
    function automatic logic [2:0] beat_offset(input logic [2:0] start,
                                               input logic [2:0] idx,
                                               input logic       bl8);
        logic [2:0] sum;
        sum = start + idx;
        return bl8 ? sum : {start[2], sum[1:0]};
    endfunction

endpackage

// File: rtl/ddr_dimm_responder_mem.sv
// Flop-array backing store for the responder: one sync write, one async read.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none, accepts a write every cycle.
//
// Ports: clock; we/waddr/wdata write port; raddr/rdata read port.
module ddr_resp_mem #(
    parameter int AW = 6,
    parameter int DW = 64
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    // Contents are intentionally not reset so data survives a responder reset.
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ddr_dimm_responder.sv
// DIMM-side responder: accepts a command and sequences ACT/PRE/BURST/RECOV.
// Latency: accept at cycle 0, burst starts at 1+T_RCD(+pre_eff for reads).
// Backpressure: dev_busy high while occupied; act_cmd then dropped (cmd_drop).
//
// Ports: clock, reset (sync, active-high); act_cmd/data_in/BL/RD_PRE command;
// wr_data write beats; dev_busy, next_cmd, dev_rd, dev_rw, rd_data, cmd_drop.
module ddr_dimm_responder
    import ddr_dimm_responder_pkg::*;
#(
    parameter int AW      = 6,
    parameter int DW      = 64,
    parameter int T_RCD   = 2,
    parameter int T_RECOV = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           act_cmd,
    input  input_data_type data_in,
    input  int             BL,
    input  int             RD_PRE,
    input  logic [DW-1:0]  wr_data,
    output logic           dev_busy,
    output logic           next_cmd,
    output logic           dev_rd,
    output logic [1:0]     dev_rw,
    output logic [DW-1:0]  rd_data,
    output logic           cmd_drop
);

    localparam int CW = 16;
    // Last count value of each timed phase. RECOV is never entered when
    // T_RECOV is 0, so its terminal value is irrelevant in that build.
    localparam logic [CW-1:0] RCD_LAST   = CW'((T_RCD > 1) ? T_RCD - 1 : 0);
    localparam logic [CW-1:0] RECOV_LAST = CW'((T_RECOV > 1) ? T_RECOV - 1 : 0);

    ddr_resp_state_t state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            rw_q;
    logic [AW-1:0]   addr_q;
    logic            bl8_q;
    logic            pre2_q;
    logic            next_cmd_q;
    logic            accept;
    logic            done_d;
    logic [AW-1:0]   beat_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_rdata;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^data_in.addr[31:AW];

    assign accept = (state == IDLE) && act_cmd;

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state;
        cnt_d   = cnt + CW'(1);
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (act_cmd) begin
                    state_d = ACT;
                end
            end
            ACT: begin
                if (cnt == RCD_LAST) begin
                    cnt_d   = '0;
                    state_d = rw_q ? PRE : BURST;
                end
            end
            PRE: begin
                if (cnt == (pre2_q ? CW'(1) : CW'(0))) begin
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (cnt == (bl8_q ? CW'(7) : CW'(3))) begin
                    cnt_d   = '0;
                    state_d = (T_RECOV == 0) ? IDLE : RECOV;
                end
            end
            RECOV: begin
                if (cnt == RECOV_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A normal completion is the only way back to IDLE that earns next_cmd;
    // reset takes priority and suppresses it.
    assign done_d = (state != IDLE) && (state_d == IDLE);

    // ------------------------------------------------------------------ registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            bl8_q      <= 1'b0;
            pre2_q     <= 1'b0;
            next_cmd_q <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            next_cmd_q <= done_d;
            if (accept) begin
                rw_q   <= data_in.rw;
                addr_q <= data_in.addr[AW-1:0];
                bl8_q  <= (BL != 4);
                pre2_q <= (RD_PRE >= 2);
            end
        end
    end

    // ------------------------------------------------------------------- datapath
    // Beat address is built from registered state only, so rd_data is a pure
    // combinational lookup of the current beat.
    assign beat_addr = {addr_q[AW-1:3], beat_offset(addr_q[2:0], cnt[2:0], bl8_q)};

    // Gating with reset keeps the beat in flight from landing when a command
    // is aborted.
    assign mem_we = (state == BURST) && !rw_q && !reset;

    ddr_resp_mem #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (beat_addr),
        .wdata (wr_data),
        .raddr (beat_addr),
        .rdata (mem_rdata)
    );

    // -------------------------------------------------------------------- outputs
    always_comb begin
        dev_rw = DEV_RW_IDLE;
        unique case (state)
            PRE:     dev_rw = DEV_RW_RD;
            BURST:   dev_rw = rw_q ? DEV_RW_RD : DEV_RW_WR;
            default: dev_rw = DEV_RW_IDLE;
        endcase
    end

    assign dev_busy = (state != IDLE);
    assign next_cmd = next_cmd_q;
    assign dev_rd   = (state == BURST) && rw_q;
    assign rd_data  = dev_rd ? mem_rdata : '0;
    assign cmd_drop = act_cmd && dev_busy;

endmodule

// File: tb/tb_ddr_dimm_responder.sv
// Self-checking bench for ddr_dimm_responder against a cycle-count/array model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ddr_dimm_responder;
    import ddr_dimm_responder_pkg::*;

    localparam int AW      = 6;
    localparam int DW      = 64;
    localparam int T_RCD   = 2;
    localparam int T_RECOV = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           act_cmd;
    logic           act_cmd0;
    input_data_type data_in;
    int             BL;
    int             RD_PRE;
    logic [DW-1:0]  wr_data;

    logic           dev_busy, next_cmd, dev_rd, cmd_drop;
    logic [1:0]     dev_rw;
    logic [DW-1:0]  rd_data;
    logic           dev_busy0, next_cmd0, dev_rd0, cmd_drop0;
    logic [1:0]     dev_rw0;
    logic [DW-1:0]  rd_data0;

    int             checks = 0;
    int             errors = 0;
    logic [63:0]    mem_m [64];
    logic [63:0]    wbuf [8];

    always #5 clock = ~clock;

    ddr_dimm_responder #(.AW(AW), .DW(DW), .T_RCD(T_RCD), .T_RECOV(T_RECOV)) dut (
        .clock(clock), .reset(reset), .act_cmd(act_cmd), .data_in(data_in),
        .BL(BL), .RD_PRE(RD_PRE), .wr_data(wr_data),
        .dev_busy(dev_busy), .next_cmd(next_cmd), .dev_rd(dev_rd),
        .dev_rw(dev_rw), .rd_data(rd_data), .cmd_drop(cmd_drop)
    );

    ddr_dimm_responder #(.AW(AW), .DW(DW), .T_RCD(T_RCD), .T_RECOV(0)) dut0 (
        .clock(clock), .reset(reset), .act_cmd(act_cmd0), .data_in(data_in),
        .BL(BL), .RD_PRE(RD_PRE), .wr_data(wr_data),
        .dev_busy(dev_busy0), .next_cmd(next_cmd0), .dev_rd(dev_rd0),
        .dev_rw(dev_rw0), .rd_data(rd_data0), .cmd_drop(cmd_drop0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic int pick_bl(input int k);
        case (k)
            0:       return 4;
            1:       return 8;
            2:       return 5;
            3:       return 0;
            4:       return 16;
            default: return -1;
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},  64'(dev_busy), 64'd0);
        check({tag, " next"},  64'(next_cmd), 64'd0);
        check({tag, " rd"},    64'(dev_rd),   64'd0);
        check({tag, " rw"},    64'(dev_rw),   64'd0);
        check({tag, " rdata"}, rd_data,       64'd0);
        check({tag, " drop"},  64'(cmd_drop), 64'd0);
    endtask

    // Drive one command into dut starting in the current cycle (cycle 0) and
    // check every output cycle by cycle up to and including the next_cmd
    // cycle. Returns mid-way through that cycle so a follow-up call issues a
    // back-to-back command. hold keeps act_cmd high (with junk payload) while
    // busy; abort_beat >= 0 asserts reset during that write/read beat.
    task automatic run_cmd(input bit rw, input int addr, input int bl_in,
                           input int pre_in, input bit hold, input int abort_beat);
        int bl     = (bl_in == 4) ? 4 : 8;
        int pre    = rw ? ((pre_in <= 1) ? 1 : 2) : 0;
        int bstart = 1 + T_RCD + pre;
        int bend   = bstart + bl - 1;
        int done   = bend + T_RECOV + 1;
        int base   = (addr / bl) * bl;
        int i;
        int a;
        bit in_beat;
        bit in_pre;
        logic [1:0] exp_rw;
        act_cmd      = 1'b1;
        data_in.rw   = rw;
        data_in.addr = 32'(addr);
        BL           = bl_in;
        RD_PRE       = pre_in;
        step();
        if (!hold) act_cmd = 1'b0;
        for (int c = 1; c <= done; c++) begin
            i       = c - bstart;
            in_beat = (i >= 0) && (i < bl);
            in_pre  = rw && (c >= bstart - pre) && (c < bstart);
            a       = in_beat ? base + ((addr % bl) + i) % bl : 0;
            if (hold && c < done) begin
                data_in.addr = $urandom;
                data_in.rw   = 1'($urandom_range(0, 1));
                BL           = int'($urandom_range(0, 9));
                RD_PRE       = int'($urandom_range(0, 4));
            end else if (hold) begin
                data_in.rw   = rw;
                data_in.addr = 32'(addr);
                BL           = bl_in;
                RD_PRE       = pre_in;
            end
            if (!rw && in_beat)
                wr_data = (i == abort_beat) ? mem_m[a] : wbuf[i];
            else
                wr_data = rnd64();
            @(negedge clock);
            exp_rw = in_beat ? (rw ? 2'b10 : 2'b01) : (in_pre ? 2'b10 : 2'b00);
            check($sformatf("busy c%0d", c),  64'(dev_busy), 64'(c < done));
            check($sformatf("next c%0d", c),  64'(next_cmd), 64'(c == done));
            check($sformatf("rd c%0d", c),    64'(dev_rd),   64'(rw && in_beat));
            check($sformatf("rw c%0d", c),    64'(dev_rw),   64'(exp_rw));
            check($sformatf("rdata c%0d", c), rd_data,       (rw && in_beat) ? mem_m[a] : 64'd0);
            check($sformatf("drop c%0d", c),  64'(cmd_drop), 64'(hold && c < done));
            if (in_beat && i == abort_beat) begin
                reset = 1'b1;
                step();
                reset   = 1'b0;
                act_cmd = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clock);
                    check_idle_outputs($sformatf("abort+%0d", k));
                    if (k < 3) step();
                end
                return;
            end
            if (!rw && in_beat) mem_m[a] = wbuf[i];
            if (c == done) return;
            step();
        end
    endtask

    initial begin
        reset    = 1'b1;
        act_cmd  = 1'b0;
        act_cmd0 = 1'b0;
        data_in  = '0;
        BL       = 8;
        RD_PRE   = 1;
        wr_data  = '0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("reset");
        check("reset busy0", 64'(dev_busy0), 64'd0);
        check("reset next0", 64'(next_cmd0), 64'd0);
        step();

        // Fill the whole array so every later read has a known expectation.
        for (int blk = 0; blk < 8; blk++) begin
            for (int k = 0; k < 8; k++) wbuf[k] = rnd64();
            run_cmd(1'b0, blk * 8, 8, 1, 1'b0, -1);
            step();
        end

        // Write then read at 0x10, data A0..A7.
        for (int k = 0; k < 8; k++) wbuf[k] = 64'hA0 + 64'(k);
        run_cmd(1'b0, 'h10, 8, 1, 1'b0, -1);
        step();
        run_cmd(1'b1, 'h10, 8, 1, 1'b0, -1);
        step();

        // Wrap inside the aligned 8-word block.
        for (int k = 0; k < 8; k++) wbuf[k] = 64'(k);
        run_cmd(1'b0, 'h0D, 8, 1, 1'b0, -1);
        step();
        run_cmd(1'b1, 'h08, 8, 0, 1'b0, -1);
        step();

        // BL4 read with two-cycle preamble; BL=5 treated as BL8.
        run_cmd(1'b1, 'h06, 4, 2, 1'b0, -1);
        step();
        for (int k = 0; k < 8; k++) wbuf[k] = rnd64();
        run_cmd(1'b0, 'h1B, 5, 3, 1'b0, -1);
        step();
        run_cmd(1'b1, 'h18, 5, 1, 1'b0, -1);
        step();

        // act_cmd held while busy: drops reported, then re-accepted back-to-back.
        for (int k = 0; k < 8; k++) wbuf[k] = rnd64();
        run_cmd(1'b0, 'h22, 8, 1, 1'b1, -1);
        run_cmd(1'b0, 'h22, 8, 1, 1'b0, -1);
        step();
        run_cmd(1'b1, 'h20, 8, 2, 1'b0, -1);
        step();

        // Reset during write beat 3: beats 0..2 retained.
        for (int k = 0; k < 8; k++) wbuf[k] = rnd64();
        run_cmd(1'b0, 'h28, 8, 1, 1'b0, 3);
        step();
        run_cmd(1'b1, 'h28, 8, 1, 1'b0, -1);
        step();

        // Randomized traffic, mixing gaps and back-to-back commands.
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < 8; k++) wbuf[k] = rnd64();
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                    pick_bl(int'($urandom_range(0, 5))),
                    int'($urandom_range(0, 4)) - 1, 1'b0, -1);
            if ($urandom_range(0, 1) == 1) step();
        end
        step();

        // T_RECOV=0 build: write BL8 at 0x30, next_cmd at cycle 11, then a
        // back-to-back read accepted in that same cycle.
        for (int k = 0; k < 8; k++) wbuf[k] = rnd64();
        act_cmd0     = 1'b1;
        data_in.rw   = 1'b0;
        data_in.addr = 32'h30;
        BL           = 8;
        RD_PRE       = 1;
        step();
        act_cmd0 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            wr_data = (c >= 3 && c <= 10) ? wbuf[c-3] : rnd64();
            @(negedge clock);
            check($sformatf("r0 wr busy c%0d", c), 64'(dev_busy0), 64'(c < 11));
            check($sformatf("r0 wr next c%0d", c), 64'(next_cmd0), 64'(c == 11));
            if (c < 11) step();
        end
        act_cmd0     = 1'b1;
        data_in.rw   = 1'b1;
        data_in.addr = 32'h30;
        step();
        act_cmd0 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            check($sformatf("r0 rd busy c%0d", c), 64'(dev_busy0), 64'(c < 12));
            check($sformatf("r0 rd next c%0d", c), 64'(next_cmd0), 64'(c == 12));
            check($sformatf("r0 rd vld c%0d", c),  64'(dev_rd0),   64'(c >= 4 && c <= 11));
            check($sformatf("r0 rdata c%0d", c), rd_data0,
                  (c >= 4 && c <= 11) ? wbuf[c-4] : 64'd0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
